// File: rtl/dac_spi_arbiter.sv
// dac_spi_arbiter: shares one DAC SPI master among NUM_REQ requesters.
// Per-transfer round-robin arbitration, optional ownership lock across
// several transfers, and a programmable chip-select idle gap between frames.
//
// state          | meaning
// ---------------+-----------------------------------------------------------
// ST_IDLE        | no frame in flight; arbitrate, or serve only the lock owner
// ST_TRANSFER    | spi_arm high, waiting for spi_finished
// ST_WAIT_DISARM | req_finished high, waiting for requester and SPI to drop
// ST_GAP         | chip-select idle gap, GAP+1 cycles
module dac_spi_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int DAC_WID = 24,
  parameter int GAP_WID = 8,
  parameter int GAP     = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_arm,
  input  logic [NUM_REQ-1:0]         req_lock,
  input  logic [NUM_REQ*DAC_WID-1:0] req_mosi,
  output logic [NUM_REQ-1:0]         req_finished,
  output logic [DAC_WID-1:0]         req_miso,
  output logic [NUM_REQ-1:0]         grant,
  output logic                       busy,
  output logic                       spi_arm,
  input  logic                       spi_finished,
  output logic [DAC_WID-1:0]         spi_mosi,
  input  logic [DAC_WID-1:0]         spi_miso
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TRANSFER,
    ST_WAIT_DISARM,
    ST_GAP
  } state_t;

  state_t             state, state_nxt;
  logic [PTR_W-1:0]   rr_ptr, rr_ptr_nxt;
  logic [PTR_W-1:0]   owner, owner_nxt;
  logic               lock_valid, lock_valid_nxt;
  logic [GAP_WID-1:0] gap_cnt, gap_cnt_nxt;
  logic [NUM_REQ-1:0] grant_nxt, req_finished_nxt;
  logic [DAC_WID-1:0] spi_mosi_nxt, req_miso_nxt;
  logic               spi_arm_nxt;

  logic               cand_hit;
  logic [PTR_W-1:0]   cand, scan_idx;
  logic               start;
  logic [PTR_W-1:0]   sel;

  // Round-robin candidate: first armed requester at or after rr_ptr, wrapping.
  always_comb begin
    cand_hit = 1'b0;
    cand     = '0;
    scan_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!cand_hit && req_arm[scan_idx]) begin
        cand_hit = 1'b1;
        cand     = scan_idx;
      end
    end
  end

  // Next-state and next-output logic; everything holds unless a state acts.
  always_comb begin
    state_nxt        = state;
    rr_ptr_nxt       = rr_ptr;
    owner_nxt        = owner;
    lock_valid_nxt   = lock_valid;
    gap_cnt_nxt      = gap_cnt;
    grant_nxt        = grant;
    req_finished_nxt = req_finished;
    spi_mosi_nxt     = spi_mosi;
    req_miso_nxt     = req_miso;
    spi_arm_nxt      = spi_arm;
    start            = 1'b0;
    sel              = cand;

    case (state)
      ST_IDLE: begin
        if (lock_valid) begin
          sel = owner;
          if (!req_lock[owner]) begin
            // Owner released the lock; open arbitration on the next cycle.
            lock_valid_nxt = 1'b0;
            grant_nxt      = '0;
          end else begin
            start = req_arm[owner];
          end
        end else begin
          start = cand_hit;
        end

        if (start) begin
          grant_nxt      = NUM_REQ'(1) << sel;
          spi_mosi_nxt   = req_mosi[int'(sel)*DAC_WID +: DAC_WID];
          spi_arm_nxt    = 1'b1;
          rr_ptr_nxt     = (int'(sel) == NUM_REQ-1) ? '0 : sel + PTR_W'(1);
          lock_valid_nxt = req_lock[sel];
          owner_nxt      = sel;
          state_nxt      = ST_TRANSFER;
        end
      end

      ST_TRANSFER: begin
        if (spi_finished) begin
          spi_arm_nxt      = 1'b0;
          req_miso_nxt     = spi_miso;
          req_finished_nxt = grant;
          state_nxt        = ST_WAIT_DISARM;
        end
      end

      ST_WAIT_DISARM: begin
        if (!req_arm[owner] && !spi_finished) begin
          req_finished_nxt = '0;
          gap_cnt_nxt      = '0;
          state_nxt        = ST_GAP;
        end
      end

      ST_GAP: begin
        if (gap_cnt != GAP_WID'(GAP)) begin
          gap_cnt_nxt = gap_cnt + GAP_WID'(1);
        end else begin
          state_nxt = ST_IDLE;
          if (!lock_valid) grant_nxt = '0;
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  // State and registered outputs; reset drops spi_arm at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      rr_ptr       <= '0;
      owner        <= '0;
      lock_valid   <= 1'b0;
      gap_cnt      <= '0;
      grant        <= '0;
      req_finished <= '0;
      spi_mosi     <= '0;
      req_miso     <= '0;
      spi_arm      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nxt;
      rr_ptr       <= rr_ptr_nxt;
      owner        <= owner_nxt;
      lock_valid   <= lock_valid_nxt;
      gap_cnt      <= gap_cnt_nxt;
      grant        <= grant_nxt;
      req_finished <= req_finished_nxt;
      spi_mosi     <= spi_mosi_nxt;
      req_miso     <= req_miso_nxt;
      spi_arm      <= spi_arm_nxt;
      busy         <= (state_nxt != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_dac_spi_arbiter.sv
// Directed bench for dac_spi_arbiter: one instance with GAP=10, one with GAP=0.
module tb_dac_spi_arbiter;
  localparam int N = 3;
  localparam int W = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [N-1:0] req_arm, req_lock;
  logic [N*W-1:0] req_mosi;
  logic [N-1:0] req_finished, grant;
  logic [W-1:0] req_miso, spi_mosi, spi_miso;
  logic         busy, spi_arm, spi_finished;

  logic [N-1:0] arm_z, lock_z, req_finished_z, grant_z;
  logic [W-1:0] req_miso_z, spi_mosi_z;
  logic         busy_z, spi_arm_z, fin_z;

  int checks = 0;
  int errors = 0;

  dac_spi_arbiter #(.NUM_REQ(N), .DAC_WID(W), .GAP_WID(8), .GAP(10)) dut (
    .clk(clk), .rst(rst), .req_arm(req_arm), .req_lock(req_lock),
    .req_mosi(req_mosi), .req_finished(req_finished), .req_miso(req_miso),
    .grant(grant), .busy(busy), .spi_arm(spi_arm),
    .spi_finished(spi_finished), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  dac_spi_arbiter #(.NUM_REQ(N), .DAC_WID(W), .GAP_WID(8), .GAP(0)) dut_z (
    .clk(clk), .rst(rst), .req_arm(arm_z), .req_lock(lock_z),
    .req_mosi(req_mosi), .req_finished(req_finished_z), .req_miso(req_miso_z),
    .grant(grant_z), .busy(busy_z), .spi_arm(spi_arm_z),
    .spi_finished(fin_z), .spi_mosi(spi_mosi_z), .spi_miso(spi_miso)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_arm(input int lim);
    int n = 0;
    while (spi_arm !== 1'b1 && n < lim) begin
      tick();
      n++;
    end
    chk("wait_spi_arm", 32'(spi_arm), 32'd1);
  endtask

  // Serve one transfer for requester idx; optionally re-raise its request.
  task automatic serve(input int idx, input logic [W-1:0] miso, input bit rearm);
    wait_arm(40);
    chk("serve_grant", 32'(grant), 32'(1 << idx));
    spi_finished = 1'b1;
    spi_miso     = miso;
    tick();
    chk("serve_finished", 32'(req_finished), 32'(1 << idx));
    chk("serve_miso", 32'(req_miso), 32'(miso));
    chk("serve_spi_arm_low", 32'(spi_arm), 32'd0);
    spi_finished = 1'b0;
    req_arm[idx] = 1'b0;
    tick();
    chk("serve_finished_clear", 32'(req_finished), 32'd0);
    if (rearm) req_arm[idx] = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_arm = '0; req_lock = '0; req_mosi = '0;
    spi_finished = 1'b0; spi_miso = '0;
    arm_z = '0; lock_z = '0; fin_z = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_spi_arm", 32'(spi_arm), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_spi_mosi", 32'(spi_mosi), 32'd0);
    chk("rst_req_miso", 32'(req_miso), 32'd0);
    chk("rst_req_finished", 32'(req_finished), 32'd0);

    // Single request with GAP=10
    req_mosi[1*W +: W] = 24'h100ABC;
    req_arm = 3'b010;
    tick();
    chk("single_grant", 32'(grant), 32'h2);
    chk("single_spi_arm", 32'(spi_arm), 32'd1);
    chk("single_spi_mosi", 32'(spi_mosi), 32'h100ABC);
    chk("single_busy", 32'(busy), 32'd1);
    tick(); tick();
    chk("single_hold_arm", 32'(spi_arm), 32'd1);
    spi_finished = 1'b1; spi_miso = 24'h912345;
    tick();
    chk("single_req_miso", 32'(req_miso), 32'h912345);
    chk("single_req_finished", 32'(req_finished), 32'h2);
    chk("single_spi_arm_low", 32'(spi_arm), 32'd0);
    spi_finished = 1'b0; req_arm = 3'b000;
    tick();
    chk("single_fin_clear", 32'(req_finished), 32'd0);
    chk("single_gap_busy", 32'(busy), 32'd1);
    req_arm = 3'b010;
    repeat (10) tick();
    chk("gap_still_busy", 32'(busy), 32'd1);
    chk("gap_no_arm", 32'(spi_arm), 32'd0);
    chk("gap_grant_held", 32'(grant), 32'h2);
    tick();
    chk("gap_end_idle", 32'(busy), 32'd0);
    chk("gap_end_grant_clr", 32'(grant), 32'd0);
    chk("gap_end_no_arm", 32'(spi_arm), 32'd0);
    tick();
    chk("regrant_arm", 32'(spi_arm), 32'd1);
    chk("regrant_grant", 32'(grant), 32'h2);
    serve(1, 24'h000111, 1'b0);
    repeat (12) tick();

    // Contention from reset: order 0,1,2,0,1,2
    rst = 1'b1; req_arm = 3'b111;
    tick();
    rst = 1'b0;
    serve(0, 24'h0A0000, 1'b1);
    serve(1, 24'h0A0001, 1'b1);
    serve(2, 24'h0A0002, 1'b1);
    serve(0, 24'h0B0000, 1'b0);
    serve(1, 24'h0B0001, 1'b0);
    serve(2, 24'h0B0002, 1'b0);
    repeat (12) tick();

    // Lock: requester 2 keeps ownership while 0 waits
    req_lock[2] = 1'b1; req_arm[2] = 1'b1;
    tick();
    chk("lock_first_grant", 32'(grant), 32'h4);
    req_arm[0] = 1'b1;
    serve(2, 24'h0C0001, 1'b1);
    serve(2, 24'h0C0002, 1'b0);
    repeat (14) tick();
    chk("lock_hold_grant", 32'(grant), 32'h4);
    chk("lock_hold_no_arm", 32'(spi_arm), 32'd0);
    chk("lock_hold_idle", 32'(busy), 32'd0);
    req_lock[2] = 1'b0;
    tick();
    chk("unlock_grant_clr", 32'(grant), 32'd0);
    tick();
    chk("unlock_grant0", 32'(grant), 32'h1);
    chk("unlock_arm", 32'(spi_arm), 32'd1);
    serve(0, 24'h0C0003, 1'b0);
    repeat (12) tick();

    // Early disarm and mosi latching
    req_mosi[0*W +: W] = 24'hA5A5A5;
    req_arm[0] = 1'b1;
    tick();
    chk("early_grant", 32'(grant), 32'h1);
    chk("early_mosi", 32'(spi_mosi), 32'hA5A5A5);
    req_mosi[0*W +: W] = 24'h0F0F0F;
    req_arm[0] = 1'b0;
    tick();
    chk("early_mosi_latched", 32'(spi_mosi), 32'hA5A5A5);
    chk("early_arm_held", 32'(spi_arm), 32'd1);
    spi_finished = 1'b1; spi_miso = 24'h3C3C3C;
    tick();
    chk("early_fin_pulse", 32'(req_finished), 32'h1);
    spi_finished = 1'b0;
    tick();
    chk("early_fin_one_cycle", 32'(req_finished), 32'd0);
    chk("early_gap_busy", 32'(busy), 32'd1);
    repeat (12) tick();

    // Reset mid-transfer; rr_ptr returns to 0 so 1 beats 2
    req_arm[1] = 1'b1;
    tick();
    chk("rmid_grant", 32'(grant), 32'h2);
    rst = 1'b1;
    tick();
    chk("rmid_spi_arm", 32'(spi_arm), 32'd0);
    chk("rmid_grant_clr", 32'(grant), 32'd0);
    chk("rmid_busy", 32'(busy), 32'd0);
    chk("rmid_spi_mosi", 32'(spi_mosi), 32'd0);
    chk("rmid_req_miso", 32'(req_miso), 32'd0);
    rst = 1'b0;
    req_arm = 3'b110;
    tick();
    chk("rmid_after_grant", 32'(grant), 32'h2);
    serve(1, 24'h0D0001, 1'b0);
    serve(2, 24'h0D0002, 1'b0);
    repeat (12) tick();

    // GAP=0 instance: exactly one GAP cycle
    arm_z = 3'b001;
    tick();
    chk("g0_grant", 32'(grant_z), 32'h1);
    chk("g0_arm", 32'(spi_arm_z), 32'd1);
    fin_z = 1'b1;
    tick();
    chk("g0_finished", 32'(req_finished_z), 32'h1);
    fin_z = 1'b0; arm_z = 3'b000;
    tick();
    chk("g0_gap_busy", 32'(busy_z), 32'd1);
    arm_z = 3'b010;
    tick();
    chk("g0_idle", 32'(busy_z), 32'd0);
    chk("g0_idle_grant", 32'(grant_z), 32'd0);
    tick();
    chk("g0_second_grant", 32'(grant_z), 32'h2);
    chk("g0_second_arm", 32'(spi_arm_z), 32'd1);
    fin_z = 1'b1;
    tick();
    fin_z = 1'b0; arm_z = 3'b000;
    tick();
    chk("g0_gap2_busy", 32'(busy_z), 32'd1);
    tick();
    chk("g0_idle2", 32'(busy_z), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dac_spi_arbiter.md
# dac_spi_arbiter

Shares one DAC SPI master among `NUM_REQ` requesters (DAC ramp, direct host write/read, scan engine) so each can issue full DAC command words without knowing about the others. Round-robin arbitration runs per transfer. An optional lock keeps ownership across multi-transfer sequences such as a read that needs two frames, or a ramp. A programmable chip-select idle gap is enforced between consecutive transfers.

## Interface
- `NUM_REQ`, 3: number of requesters; fixed priority order is index 0 highest within the round-robin rotation.
- `DAC_WID`, 24: SPI frame width (4-bit command + 20-bit data).
- `GAP_WID`, 8: width of gap counter.
- `GAP`, 10: idle cycles inserted after each transfer; GAP state lasts `GAP+1` cycles.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `req_arm` in NUM_REQ: per-requester transfer request; held high until matching `req_finished`.
- `req_lock` in NUM_REQ: requester keeps ownership after its transfer while high.
- `req_mosi` in NUM_REQ*DAC_WID: flattened frames; requester i occupies bits `[i*DAC_WID +: DAC_WID]`; stable while `req_arm[i]` high.
- `req_finished` out NUM_REQ: one-hot; transfer done for the granted requester.
- `req_miso` out DAC_WID: last received frame, shared by all requesters.
- `grant` out NUM_REQ: one-hot current owner, all-zero when idle.
- `busy` out 1: high in every state except IDLE.
- `spi_arm` out 1: arm to SPI master.
- `spi_finished` in 1: SPI master done, held while `spi_arm` high.
- `spi_mosi` out DAC_WID: latched frame to SPI master.
- `spi_miso` in DAC_WID: frame from SPI master, valid with `spi_finished`.

## Operation
- States: IDLE, TRANSFER, WAIT_DISARM, GAP.
- IDLE, no lock owner:
  - Candidate = first i with `req_arm[i]`, scanning from `rr_ptr` upward with wraparound.
  - On a hit: `grant <= onehot(i)`, `spi_mosi <= req_mosi[i]`, `spi_arm <= 1`, `rr_ptr <= (i+1) mod NUM_REQ`, `lock_valid <= req_lock[i]`, go to TRANSFER.
- IDLE, lock owner L:
  - If `req_lock[L]` is low, clear `lock_valid` and `grant`; arbitration resumes the next cycle.
  - Otherwise only `req_arm[L]` is considered; `grant` stays `onehot(L)` and other requesters wait.
- TRANSFER: on `spi_finished`:
  - `spi_arm <= 0`, `req_miso <= spi_miso`, `req_finished[g] <= 1`, go to WAIT_DISARM.
- WAIT_DISARM: when `req_arm[g]==0` and `spi_finished==0`:
  - `req_finished <= 0`, `gap_cnt <= 0`, go to GAP.
- GAP:
  - While `gap_cnt != GAP`, increment `gap_cnt`.
  - Otherwise go to IDLE; `grant` clears unless `lock_valid` is set.
- `req_mosi` is latched once at grant. Later changes have no effect on the frame in flight.
- Simultaneous requests are resolved by rotation only; no requester is starved, and each waits at most `NUM_REQ-1` transfers without locks.
- Requester dropping `req_arm` during TRANSFER: the transfer completes and `req_finished` pulses for 1 cycle, since WAIT_DISARM exits immediately.
- `req_lock` without `req_arm` in IDLE while the owner: ownership is held indefinitely. This is intended, and the host must release the lock.
- Reset, any state:
  - Outputs: `grant`, `req_finished`, `spi_arm`, `busy` = 0; `spi_mosi`, `req_miso` = 0.
  - Internal: `rr_ptr=0`, `lock_valid=0`, `gap_cnt=0`, state IDLE.
  - Mid-transfer reset drops `spi_arm` immediately. The SPI master is required to abort on arm loss.

## Timing
- All outputs are registered.
- Request to grant: `req_arm` high at edge k (IDLE) gives `grant`, `spi_arm`, `spi_mosi` valid after edge k.
- `spi_finished` sampled at edge m gives `req_finished`, `req_miso` valid after m; `spi_arm` low after m.
- Disarm sampled at edge n: GAP occupies edges n+1 … n+GAP+1; IDLE is re-entered and able to grant at the following edge.
- Back-to-back throughput overhead is 1 (grant) + 1 (finish) + disarm latency + GAP+1 + 1 cycles per frame.

## Test plan
- Single request, GAP=10:
  - `req_arm[1]` with `req_mosi[1]=24'h1_00ABC` gives `grant=3'b010`, `spi_mosi=24'h100ABC` and `spi_arm` 1 cycle later.
  - `spi_finished` with `spi_miso=24'h912345` gives `req_miso=24'h912345` and `req_finished=3'b010`.
  - Next grant no earlier than 11 cycles after disarm.
- Contention: all three `req_arm` high from reset, each held until finished and re-raised → grant order 0,1,2,0,1,2.
- Lock:
  - `req_lock[2]=1`, requester 2 issues two transfers while `req_arm[0]` is high: both go to 2 and 0 waits.
  - Dropping `req_lock[2]` in IDLE gives grant to 0 within 2 cycles.
- Early disarm: `req_arm[0]` dropped during TRANSFER → `req_finished[0]` is a 1-cycle pulse; `spi_mosi` is unchanged despite `req_mosi` changing mid-transfer.
- Reset mid-transfer: `rst` pulsed in TRANSFER → next cycle `spi_arm=0`, `grant=0`, `busy=0`; a subsequent `req_arm[2]` is granted before `req_arm[1]` raised the same cycle only if `rr_ptr` permits, i.e. 1 wins after reset.
- GAP=0: consecutive transfers show exactly one GAP cycle between disarm and IDLE.
